uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side byte buffer between the UART receiver and the wishbone control/register block.
- Drains each completed byte from the receiver via a level handshake, into a DEPTH-entry FIFO, with a per-entry frame-error bit.
- Presents first-word-fall-through read data, status, a sticky overflow flag and a threshold interrupt to the control block, so software tolerates back-to-back frames without losing bytes.

Parameters:
DEPTH, 16, number of entries; power of two, >= 2
ADDR_W, 4, log2(DEPTH); pointer width

Ports:
clk  input  1  system clock (wishbone clock); all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
i_rx_irq  input  1  receiver holds a completed byte (level)
i_rx_data  input  8  byte from receiver, stable while i_rx_irq=1
i_frame_err  input  1  frame error of the held byte, stable while i_rx_irq=1
o_rx_finish  output  1  clear request to receiver (level, handshake)
i_rd_en  input  1  pop head entry (one pop per cycle high)
o_rd_data  output  8  head entry data (fall-through)
o_rd_frame_err  output  1  head entry frame-error bit
o_empty  output  1  count == 0
o_full  output  1  count == DEPTH
o_count  output  ADDR_W+1  entries held, 0..DEPTH
o_overflow  output  1  sticky: a byte was dropped because FIFO was full
i_clr_overflow  input  1  clear o_overflow
i_flush  input  1  discard all entries
i_thresh  input  ADDR_W+1  interrupt threshold; 0 disables
o_irq  output  1  threshold interrupt (level)

Behaviour:
- Reset (rst_n=0 at edge): pointers=0, o_count=0, o_empty=1, o_full=0, o_overflow=0, o_rx_finish=0, o_irq=0, FSM=IDLE; o_rd_data/o_rd_frame_err=0 while empty. Reset mid-handshake returns to IDLE; the receiver is not acknowledged.
- Storage: DEPTH x 9 bits {frame_err, data}; wr_ptr/rd_ptr ADDR_W bits, wrap DEPTH-1 -> 0 by natural overflow; occupancy tracked by separate o_count register.
- Capture FSM, states IDLE, ACK:
  - IDLE, i_rx_irq=1: write accepted if (!o_full || pop this cycle). Accepted: entry written, wr_ptr+1 at this edge. Not accepted: byte dropped, o_overflow<=1. Either way -> ACK with o_rx_finish=1 from next cycle.
  - ACK: o_rx_finish held 1 while i_rx_irq=1; when i_rx_irq=0 sampled -> IDLE, o_rx_finish<=0.
  - Exactly one byte captured per i_rx_irq high period; no capture in ACK.
- Read: pop when i_rd_en=1 and o_empty=0; rd_ptr+1 at the edge. i_rd_en while empty ignored; no state change, no flag.
- o_rd_data/o_rd_frame_err = mem[rd_ptr] when not empty (combinational from registered pointer and memory). Zero when empty.
- o_count: +1 on write only, -1 on pop only, unchanged on simultaneous write+pop. Push into full allowed only with same-cycle pop; count stays DEPTH.
- o_empty/o_full registered alongside o_count, consistent with it every cycle.
- Latency: i_rx_irq sampled at edge N -> o_count, o_empty, o_rd_data valid after edge N; o_rx_finish=1 after edge N.
- i_flush (priority over write and pop same cycle): pointers=0, count=0. A capture in the same cycle is discarded, but the FSM still enters ACK. o_overflow unaffected.
- o_overflow: set on drop; cleared by i_clr_overflow. Set wins if both occur in the same cycle.
- o_irq registered: o_irq <= (i_thresh != 0) && (next count >= i_thresh). Asserted the cycle after the count reaches the threshold. Threshold > DEPTH never fires.

Test Plan:
- Single byte: i_rx_irq=1 with 0xA5, fe=0; drop irq 3 cycles after o_rx_finish -> count=1, o_rd_data=0xA5, o_rx_finish high 3 cycles then 0; pop -> empty=1, rd_data=0.
- Fill/overflow: 17 handshakes with bytes 0x00..0x10, DEPTH=16 -> full=1 after 16th; 17th dropped but acked, o_overflow=1; pops return 0x00..0x0F in order; i_clr_overflow -> 0.
- Wrap and frame-error: push 10, pop 10, push 10 with byte 0x3C fe=1 at 5th -> pointers wrap, order preserved, o_rd_frame_err=1 only with 0x3C.
- Simultaneous: FIFO full, i_rd_en with new i_rx_irq same edge -> count stays 16, no overflow, new byte is last out.
- Threshold/flush: i_thresh=4, push 4 -> o_irq=1 cycle after 4th write; i_flush with concurrent capture -> count=0, o_irq=0 next cycle, FSM completes ACK; i_thresh=0 -> o_irq never asserts.
- Reset mid-ACK: rst_n=0 while o_rx_finish=1 -> next cycle o_rx_finish=0, count=0, empty=1, overflow=0.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Bus between the receive FIFO, the UART receiver and the control block.
// The slave modport is the FIFO view; the master modport is the
// receiver/control-block view.
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    // receiver handshake
    logic              i_rx_irq;
    logic [7:0]        i_rx_data;
    logic              i_frame_err;
    logic              o_rx_finish;
    // control block read port and status
    logic              i_rd_en;
    logic [7:0]        o_rd_data;
    logic              o_rd_frame_err;
    logic              o_empty;
    logic              o_full;
    logic [ADDR_W:0]   o_count;
    logic              o_overflow;
    logic              i_clr_overflow;
    logic              i_flush;
    logic [ADDR_W:0]   i_thresh;
    logic              o_irq;

    modport slave (
        input  i_rx_irq, i_rx_data, i_frame_err, i_rd_en,
               i_clr_overflow, i_flush, i_thresh,
        output o_rx_finish, o_rd_data, o_rd_frame_err, o_empty, o_full,
               o_count, o_overflow, o_irq
    );

    modport master (
        output i_rx_irq, i_rx_data, i_frame_err, i_rd_en,
               i_clr_overflow, i_flush, i_thresh,
        input  o_rx_finish, o_rd_data, o_rd_frame_err, o_empty, o_full,
               o_count, o_overflow, o_irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO: captures one byte per receiver handshake into a
// DEPTH-entry buffer with per-entry frame-error bit, presents fall-through
// read data, status, a sticky overflow flag and a threshold interrupt.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_fifo_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1'b1);
    localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W + 1)'(1'b0);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(1'b0);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;
    logic              finish_q, finish_d;
    logic              irq_q, irq_d;
    logic [8:0]        mem_q [DEPTH];
    logic [8:0]        mem_d [DEPTH];

    logic              capture_s;
    logic              pop_s;
    logic              accept_s;
    logic              wr_s;
    logic              drop_s;

    // Capture FSM: one capture on IDLE->ACK, hold ACK until the receiver drops its request
    always_comb begin
        state_d   = state_q;
        capture_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_rx_irq) begin
                    state_d   = ST_ACK;
                    capture_s = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (bus.i_rx_irq) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        finish_d = (state_d == ST_ACK);
    end

    // Write/pop decisions: a full FIFO still accepts when the head leaves the same cycle
    always_comb begin
        pop_s    = bus.i_rd_en && !empty_q;
        accept_s = !full_q || pop_s;
        wr_s     = capture_s && accept_s && !bus.i_flush;
        drop_s   = capture_s && !accept_s;
    end

    // Pointer and occupancy update; flush overrides both write and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.i_flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            wr_ptr_d = wr_s  ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
            case ({wr_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
        empty_d = (count_d == CNT_ZERO);
        full_d  = (count_d == CNT_FULL);
        irq_d   = (bus.i_thresh != CNT_ZERO) && (count_d >= bus.i_thresh);
    end

    // Sticky overflow: a drop wins over a same-cycle clear
    always_comb begin
        overflow_d = overflow_q;
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (bus.i_clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Storage write: the accepted byte lands at the write pointer
    always_comb begin
        mem_d = mem_q;
        if (wr_s) begin
            mem_d[wr_ptr_q] = {bus.i_frame_err, bus.i_rx_data};
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end
    end

    // Control and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            finish_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            finish_q   <= finish_d;
            irq_q      <= irq_d;
        end
    end

    // Storage array; contents are masked by the empty flag so no reset is needed
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.o_rx_finish    = finish_q;
    assign bus.o_rd_data      = empty_q ? 8'h00 : mem_q[rd_ptr_q][7:0];
    assign bus.o_rd_frame_err = empty_q ? 1'b0  : mem_q[rd_ptr_q][8];
    assign bus.o_empty        = empty_q;
    assign bus.o_full         = full_q;
    assign bus.o_count        = count_q;
    assign bus.o_overflow     = overflow_q;
    assign bus.o_irq          = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed handshakes, scoreboard of expected pops
// checked by an independent monitor, plus direct status checks.
module tb_uart_rx_fifo;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    logic [8:0] exp_q [$];
    logic [8:0] mon_exp;

    uart_rx_fifo_if #(.ADDR_W(4)) bus ();

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every pop the DUT performs must match the scoreboard head
    always @(negedge clk) begin
        if (rst_n && bus.i_rd_en && !bus.o_empty) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL pop_unexpected: got 0x%0h required none",
                         {bus.o_rd_frame_err, bus.o_rd_data});
            end else begin
                mon_exp = exp_q.pop_front();
                check("pop_data", {23'd0, bus.o_rd_frame_err, bus.o_rd_data}, {23'd0, mon_exp});
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Short handshake: raise request, see ack, drop request next cycle
    task automatic send_fast(input logic [7:0] d, input logic fe);
        @(posedge clk); #1;
        bus.i_rx_irq    = 1'b1;
        bus.i_rx_data   = d;
        bus.i_frame_err = fe;
        @(posedge clk); #1;
        check("ack_high", {31'd0, bus.o_rx_finish}, 32'd1);
        bus.i_rx_irq = 1'b0;
    endtask

    task automatic pop_n(input int n);
        @(posedge clk); #1;
        bus.i_rd_en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        bus.i_rd_en = 1'b0;
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst_n           = 1'b0;
        bus.i_rx_irq    = 1'b0;
        bus.i_rx_data   = 8'h00;
        bus.i_frame_err = 1'b0;
        bus.i_rd_en     = 1'b0;
        bus.i_clr_overflow = 1'b0;
        bus.i_flush     = 1'b0;
        bus.i_thresh    = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count",    {27'd0, bus.o_count}, 32'd0);
        check("rst_empty",    {31'd0, bus.o_empty}, 32'd1);
        check("rst_full",     {31'd0, bus.o_full}, 32'd0);
        check("rst_overflow", {31'd0, bus.o_overflow}, 32'd0);
        check("rst_finish",   {31'd0, bus.o_rx_finish}, 32'd0);
        check("rst_irq",      {31'd0, bus.o_irq}, 32'd0);
        check("rst_rd_data",  {24'd0, bus.o_rd_data}, 32'd0);
        rst_n = 1'b1;

        // Single byte with a 3-cycle ack
        @(posedge clk); #1;
        bus.i_rx_irq = 1'b1; bus.i_rx_data = 8'hA5; bus.i_frame_err = 1'b0;
        exp_q.push_back(9'h0A5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("single_ack", {31'd0, bus.o_rx_finish}, 32'd1);
        end
        check("single_count", {27'd0, bus.o_count}, 32'd1);
        check("single_head",  {24'd0, bus.o_rd_data}, 32'hA5);
        bus.i_rx_irq = 1'b0;
        @(posedge clk); #1;
        check("single_ack_low", {31'd0, bus.o_rx_finish}, 32'd0);
        pop_n(1);
        check("single_empty", {31'd0, bus.o_empty}, 32'd1);
        check("single_rd_zero", {24'd0, bus.o_rd_data}, 32'd0);

        // Fill to 16 then overflow on the 17th
        for (int i = 0; i < 17; i++) begin
            send_fast(8'(i), 1'b0);
            if (i < 16) exp_q.push_back({1'b0, 8'(i)});
            if (i == 15) begin
                check("fill_full", {31'd0, bus.o_full}, 32'd1);
                check("fill_no_ovf", {31'd0, bus.o_overflow}, 32'd0);
            end
        end
        check("ovf_set",   {31'd0, bus.o_overflow}, 32'd1);
        check("ovf_count", {27'd0, bus.o_count}, 32'd16);
        pop_n(16);
        check("fill_drained", {31'd0, bus.o_empty}, 32'd1);
        @(posedge clk); #1; bus.i_clr_overflow = 1'b1;
        @(posedge clk); #1; bus.i_clr_overflow = 1'b0;
        check("ovf_clear", {31'd0, bus.o_overflow}, 32'd0);

        // Wrap with frame error on one entry
        for (int i = 0; i < 10; i++) begin
            send_fast(8'h20 + 8'(i), 1'b0);
            exp_q.push_back({1'b0, 8'h20 + 8'(i)});
        end
        pop_n(10);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                send_fast(8'h3C, 1'b1);
                exp_q.push_back(9'h13C);
            end else begin
                send_fast(8'h30 + 8'(i), 1'b0);
                exp_q.push_back({1'b0, 8'h30 + 8'(i)});
            end
        end
        check("wrap_count", {27'd0, bus.o_count}, 32'd10);
        pop_n(10);
        check("wrap_empty", {31'd0, bus.o_empty}, 32'd1);

        // Full FIFO with simultaneous pop and capture
        for (int i = 0; i < 16; i++) begin
            send_fast(8'h40 + 8'(i), 1'b0);
            exp_q.push_back({1'b0, 8'h40 + 8'(i)});
        end
        exp_q.push_back(9'h099);
        @(posedge clk); #1;
        bus.i_rd_en = 1'b1; bus.i_rx_irq = 1'b1; bus.i_rx_data = 8'h99; bus.i_frame_err = 1'b0;
        @(posedge clk); #1;
        bus.i_rd_en = 1'b0; bus.i_rx_irq = 1'b0;
        check("simul_count", {27'd0, bus.o_count}, 32'd16);
        check("simul_no_ovf", {31'd0, bus.o_overflow}, 32'd0);
        check("simul_full", {31'd0, bus.o_full}, 32'd1);
        pop_n(16);
        check("simul_empty", {31'd0, bus.o_empty}, 32'd1);

        // Threshold interrupt and flush with concurrent capture
        bus.i_thresh = 5'd4;
        for (int i = 0; i < 4; i++) begin
            send_fast(8'h50 + 8'(i), 1'b0);
            if (i == 2) check("thr_below", {31'd0, bus.o_irq}, 32'd0);
        end
        check("thr_fire",  {31'd0, bus.o_irq}, 32'd1);
        check("thr_count", {27'd0, bus.o_count}, 32'd4);
        @(posedge clk); #1;
        bus.i_flush = 1'b1; bus.i_rx_irq = 1'b1; bus.i_rx_data = 8'h77;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        check("flush_count", {27'd0, bus.o_count}, 32'd0);
        check("flush_empty", {31'd0, bus.o_empty}, 32'd1);
        check("flush_irq",   {31'd0, bus.o_irq}, 32'd0);
        check("flush_ack",   {31'd0, bus.o_rx_finish}, 32'd1);
        bus.i_rx_irq = 1'b0;
        @(posedge clk); #1;
        check("flush_ack_done", {31'd0, bus.o_rx_finish}, 32'd0);
        check("flush_still_empty", {31'd0, bus.o_empty}, 32'd1);
        bus.i_thresh = 5'd0;
        for (int i = 0; i < 4; i++) begin
            send_fast(8'h60 + 8'(i), 1'b0);
            check("thr_zero_quiet", {31'd0, bus.o_irq}, 32'd0);
        end
        check("thr_zero_count", {27'd0, bus.o_count}, 32'd4);

        // Reset in the middle of an ack
        @(posedge clk); #1;
        bus.i_rx_irq = 1'b1; bus.i_rx_data = 8'h55;
        @(posedge clk); #1;
        check("midrst_ack", {31'd0, bus.o_rx_finish}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_finish",   {31'd0, bus.o_rx_finish}, 32'd0);
        check("midrst_count",    {27'd0, bus.o_count}, 32'd0);
        check("midrst_empty",    {31'd0, bus.o_empty}, 32'd1);
        check("midrst_overflow", {31'd0, bus.o_overflow}, 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        bus.i_rx_irq = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", {31'd0, bus.o_rx_finish}, 32'd0);

        check("scoreboard_left", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
